// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div with a busy window,
// plus direct HI/LO writes (mthi/mtlo). The result commits on the last busy edge.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_Ctr,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          is_md_op;
  logic          is_mult_op;

  // Arithmetic datapath, fed only by the latched operands.
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic [31:0]        num, den, den_safe, uq, ur, quot, rem;

  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide runs on magnitudes; this also yields 0x80000000 / -1 = 0x80000000.
    div_signed = (op_q == OP_DIV);
    num        = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    den        = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    den_safe   = (den == 32'd0) ? 32'd1 : den;
    uq         = num / den_safe;
    ur         = num % den_safe;
    quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    rem        = (div_signed && a_q[31]) ? (32'd0 - ur) : ur;
  end

  always_comb begin
    is_md_op   = (E_MDU_Ctr == OP_MULT) || (E_MDU_Ctr == OP_MULTU) ||
                 (E_MDU_Ctr == OP_DIV)  || (E_MDU_Ctr == OP_DIVU);
    is_mult_op = (E_MDU_Ctr == OP_MULT) || (E_MDU_Ctr == OP_MULTU);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    E_Start = is_md_op && !Req && (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (E_Start) begin
          state_d = S_BUSY;
          op_d    = op_e'(E_MDU_Ctr);
          a_d     = E_A;
          b_d     = E_B;
          cnt_d   = is_mult_op ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (!Req) begin
          if (E_MDU_Ctr == OP_MTHI) begin
            hi_d = E_A;
          end else if (E_MDU_Ctr == OP_MTLO) begin
            lo_d = E_A;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        // Last busy edge: commit and drop busy together so HI/LO are fresh when busy falls.
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          op_d    = OP_NONE;
          case (op_q)
            OP_MULT: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quot;
              end
            end
            default: begin
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign E_Busy = (state_q == S_BUSY);
  assign E_HI   = hi_q;
  assign E_LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases followed by random ops,
// compared against a plain-arithmetic HI/LO model.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctr;
  logic [31:0] a, b;
  logic        req;
  logic        start, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDU_Ctr(ctr), .E_A(a), .E_B(b), .Req(req),
    .E_Start(start), .E_Busy(busy), .E_HI(hi), .E_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted op on HI/LO, plus its busy length.
  task automatic model(input logic [3:0] op, input logic [31:0] oa, input logic [31:0] ob,
                       output int n);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'(int'(oa));
    sb = longint'(int'(ob));
    ua = {32'd0, oa};
    ub = {32'd0, ob};
    n  = 0;
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; n = MC; end
      4'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; n = MC; end
      4'd3: begin
        n = DC;
        if (ob != 32'd0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      4'd4: begin
        n = DC;
        if (ob != 32'd0) begin m_lo = oa / ob; m_hi = oa % ob; end
      end
      4'd7: m_hi = oa;
      4'd8: m_lo = oa;
      default: ;
    endcase
  endtask

  // Issue one op with Req=0 and follow it to completion; operands are scrambled
  // after the start edge. req_at / inj_at pick a busy cycle to raise Req or present a mult.
  task automatic do_op(input logic [3:0] op, input logic [31:0] oa, input logic [31:0] ob,
                       input int req_at, input int inj_at);
    int n, cyc;
    logic [31:0] hi0, lo0;
    logic exp_start;
    ctr = op; a = oa; b = ob; req = 1'b0;
    #1;
    exp_start = (op >= 4'd1) && (op <= 4'd4);
    chk("start", 32'(start), 32'(exp_start));
    hi0 = m_hi; lo0 = m_lo;
    model(op, oa, ob, n);
    tick();
    ctr = 4'd0; a = $urandom; b = $urandom;
    if (exp_start) begin
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
        chk("hold_hi", hi, hi0);
        chk("hold_lo", lo, lo0);
        req = (req_at >= 0) && (cyc >= req_at);
        ctr = (cyc == inj_at) ? 4'd1 : 4'd0;
        if (cyc == inj_at) begin
          #1;
          chk("inj_start", 32'(start), 32'd0);
        end
        tick();
        cyc++;
      end
      ctr = 4'd0; req = 1'b0;
      chk("busy_cycles", 32'(cyc), 32'(n));
    end else begin
      chk("no_busy", 32'(busy), 32'd0);
    end
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  initial begin
    logic [3:0] op_tab [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd9, 4'd15};
    logic [31:0] ra, rb;
    int ri;

    reset = 1'b1; ctr = 4'd0; a = 32'd0; b = 32'd0; req = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    #2 reset = 1'b0;

    // First edge after reset release takes the mult.
    do_op(4'd1, 32'hFFFFFFFE, 32'd3, -1, -1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    do_op(4'd2, 32'hFFFFFFFE, 32'd3, -1, -1);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    do_op(4'd3, 32'hFFFFFFF9, 32'd2, -1, -1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    do_op(4'd4, 32'hFFFFFFF9, 32'd2, -1, -1);
    chk("divu_lo", lo, 32'h7FFFFFFC);
    chk("divu_hi", hi, 32'h00000001);

    // mthi then divide-by-zero, with a mult presented at busy cycle 3.
    do_op(4'd7, 32'h00001234, 32'd0, -1, -1);
    do_op(4'd4, 32'h00000055, 32'd0, -1, 2);
    chk("dz_hi", hi, 32'h00001234);
    chk("dz_lo", lo, 32'h7FFFFFFC);

    // Flushed ops: mult and mthi with Req=1.
    ctr = 4'd1; a = 32'd6; b = 32'd7; req = 1'b1;
    #1;
    chk("req_start", 32'(start), 32'd0);
    tick();
    chk("req_busy", 32'(busy), 32'd0);
    chk("req_hi", hi, m_hi);
    chk("req_lo", lo, m_lo);
    ctr = 4'd7; a = 32'hDEADBEEF;
    tick();
    chk("req_mthi", hi, m_hi);
    ctr = 4'd0; req = 1'b0;

    // Req raised mid-mult does not abort.
    do_op(4'd1, 32'd7, 32'd9, 1, -1);
    chk("reqmid_lo", lo, 32'd63);
    chk("reqmid_hi", hi, 32'd0);

    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h00000000);
    do_op(4'd7, 32'hA5A5A5A5, 32'd0, -1, -1);

    // Reset at busy cycle 4 of a div clears state before the next edge.
    ctr = 4'd3; a = 32'd100; b = 32'd7;
    tick();
    ctr = 4'd0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    #2 reset = 1'b0;
    tick();
    chk("arst_idle", 32'(busy), 32'd0);
    chk("arst_hi2", hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ri = $urandom_range(10, 0);
      ra = $urandom;
      rb = ($urandom_range(5, 0) == 0) ? 32'd0 :
           ($urandom_range(1, 0) == 1) ? 32'($urandom_range(20, 1)) : 32'($urandom);
      if ($urandom_range(1, 0) == 1) ra = 32'd0 - 32'($urandom_range(1000, 0));
      do_op(op_tab[ri], ra, rb, ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 0)) : -1, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port E_MDU_Ctr  input  4  E-stage MDU opcode: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo; all other codes behave as none.
REQ-006 SHALL have port E_A  input  32  forwarded rs operand.
REQ-007 SHALL have port E_B  input  32  forwarded rt operand.
REQ-008 SHALL have port Req  input  1  exception/interrupt request; when high, the E-stage instruction is flushed.
REQ-009 SHALL have port E_Start  output  1  combinational: the current E-stage op is accepted this cycle.
REQ-010 SHALL have port E_Busy  output  1  registered: a mult/div is in flight.
REQ-011 SHALL have port E_HI  output  32  architectural HI register, consumed by the mfhi read mux.
REQ-012 SHALL have port E_LO  output  32  architectural LO register, consumed by the mflo read mux.

Function
REQ-013 E_Start SHALL be 1 only when E_MDU_Ctr is in {0001..0100}, Req is 0, and E_Busy is 0.
REQ-014 On an edge with E_Start=1, the block SHALL latch both operands and the op, load a down-counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu), and set E_Busy=1.
REQ-015 On each later edge while busy, the counter SHALL decrement by 1; on the edge where it reaches 0, the block SHALL write HI/LO and clear E_Busy in that same edge.
- E_Busy is high for exactly N cycles.
- New HI/LO are visible in the first cycle with E_Busy=0.
REQ-016 E_HI/E_LO SHALL hold their previous values throughout the busy window.
REQ-017 mult SHALL compute the signed 64-bit product and multu the unsigned one; HI = bits[63:32], LO = bits[31:0].
REQ-018 div/divu SHALL compute quotient into LO and remainder into HI, signed (truncate toward zero, remainder takes the dividend's sign) or unsigned respectively.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 A divide with latched divisor 0 SHALL still assert busy for DIV_CYCLES but leave HI and LO unchanged.
REQ-021 mthi (mtlo) with Req=0 and E_Busy=0 SHALL write E_A into HI (LO) on the next edge, with no busy.
REQ-022 mthi/mtlo SHALL be ignored when Req=1 or E_Busy=1.
REQ-023 mult/div ops presented while E_Busy=1 SHALL be ignored; upstream stall logic guarantees they are held.
REQ-024 Req asserted mid-operation SHALL NOT abort the in-flight operation; it completes and commits normally.
REQ-025 mfhi/mflo/none SHALL have no effect on state.
REQ-026 Operand changes after the start edge SHALL NOT affect the result.

Reset
REQ-027 When reset=1, asynchronously and independent of clk: HI=0, LO=0, E_Busy=0, counter=0, latched op=none.
REQ-028 Reset SHALL abort any in-flight operation with no commit.
REQ-029 The first edge after reset deasserts SHALL accept a new start.

Verification
REQ-030 mult with A=0xFFFFFFFE, B=3 -> E_Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
REQ-032 div with A=0xFFFFFFF9 (-7), B=2 -> E_Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. The same operands on divu -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-033 mthi 0x1234 then divu with B=0 -> HI stays 0x00001234 and LO stays unchanged after 10 busy cycles; a mult issued at busy cycle 3 is ignored (E_Start=0).
REQ-034 mult issued with Req=1 -> E_Start=0, E_Busy stays 0, HI/LO unchanged.
REQ-035 Req raised at busy cycle 2 of a mult -> result still commits at cycle 5.
REQ-036 reset pulsed at busy cycle 4 of a div -> E_Busy=0 and HI=LO=0 immediately, before the next clk edge.
